// File: rtl/cpu_pkg.sv
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared types for the unified-memory port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Pipeline request/ack bundle plus the memory-side port.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int WIDTH            = 32,
    parameter int INSTRUCTIONWIDTH = 16
) ();

    logic                        fetchReq;
    logic [WIDTH-1:0]            fetchAddr;
    logic                        fetchAck;
    logic [INSTRUCTIONWIDTH-1:0] fetchData;
    logic                        dataReq;
    logic                        dataWrite;
    logic [WIDTH-1:0]            dataAddr;
    logic [WIDTH-1:0]            dataWdata;
    logic                        dataAck;
    logic [WIDTH-1:0]            dataRdata;
    logic                        memEnable;
    logic                        memWrite;
    logic [WIDTH-1:0]            memAddr;
    logic [WIDTH-1:0]            memWdata;
    logic [WIDTH-1:0]            memRdata;
    logic                        stallFetch;
    logic                        stallData;
    logic                        busy;

    modport slave (
        input  fetchReq, fetchAddr, dataReq, dataWrite, dataAddr, dataWdata, memRdata,
        output fetchAck, fetchData, dataAck, dataRdata,
        output memEnable, memWrite, memAddr, memWdata,
        output stallFetch, stallData, busy
    );

    modport master (
        output fetchReq, fetchAddr, dataReq, dataWrite, dataAddr, dataWdata, memRdata,
        input  fetchAck, fetchData, dataAck, dataRdata,
        input  memEnable, memWrite, memAddr, memWdata,
        input  stallFetch, stallData, busy
    );

endinterface

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module   : mem_arb_pick
// Purpose  : Combinational owner choice: data first unless fetch is starved.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arb_pick
    import cpu_pkg::*;
#(
    parameter int STARVELIMIT = 3,
    parameter int SW          = 2
) (
    input  wire logic          fetchReq_i,
    input  wire logic          dataReq_i,
    input  wire logic [SW-1:0] streak_i,
    output arb_owner_t         owner_o
);

    always_comb begin
        owner_o = OWN_DATA;
        if (fetchReq_i && (!dataReq_i || (streak_i == SW'(STARVELIMIT)))) begin
            owner_o = OWN_FETCH;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Serialises fetch and data accesses onto one fixed-latency memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int INSTRUCTIONWIDTH = 16,
    parameter int LATENCY          = 2,
    parameter int STARVELIMIT      = 3
) (
    input  wire logic         clock,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int SW = (STARVELIMIT > 0) ? $clog2(STARVELIMIT + 1) : 1;

    arb_state_t       state_q,  state_d;
    arb_owner_t       owner_q,  owner_d;
    arb_owner_t       w_pick;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [SW-1:0]    streak_q, streak_d;
    logic [WIDTH-1:0] addr_q,   addr_d;
    logic [WIDTH-1:0] wdata_q,  wdata_d;
    logic [WIDTH-1:0] rdata_q,  rdata_d;
    logic             write_q,  write_d;

    mem_arb_pick #(
        .STARVELIMIT (STARVELIMIT),
        .SW          (SW)
    ) u_pick (
        .fetchReq_i (bus.fetchReq),
        .dataReq_i  (bus.dataReq),
        .streak_i   (streak_q),
        .owner_o    (w_pick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_FETCH;
            cnt_q    <= '0;
            streak_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            write_q  <= write_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        write_d  = write_q;
        case (state_q)
            IDLE: begin
                if (bus.fetchReq || bus.dataReq) begin
                    state_d = ACCESS;
                    cnt_d   = CW'(LATENCY - 1);
                    owner_d = w_pick;
                    if (w_pick == OWN_FETCH) begin
                        addr_d   = bus.fetchAddr;
                        wdata_d  = '0;
                        write_d  = 1'b0;
                        streak_d = '0;
                    end else begin
                        addr_d  = bus.dataAddr;
                        wdata_d = bus.dataWdata;
                        write_d = bus.dataWrite;
                        // Only data grants that bypass a waiting fetch count toward starvation.
                        if (!bus.fetchReq) begin
                            streak_d = '0;
                        end else if (streak_q != SW'(STARVELIMIT)) begin
                            streak_d = streak_q + SW'(1);
                        end
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    rdata_d = bus.memRdata;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.memEnable  = (state_q == ACCESS);
    assign bus.memWrite   = (state_q == ACCESS) && write_q && (cnt_q == '0);
    assign bus.memAddr    = addr_q;
    assign bus.memWdata   = wdata_q;
    assign bus.fetchAck   = (state_q == RESP) && (owner_q == OWN_FETCH);
    assign bus.dataAck    = (state_q == RESP) && (owner_q == OWN_DATA);
    assign bus.fetchData  = rdata_q[INSTRUCTIONWIDTH-1:0];
    assign bus.dataRdata  = rdata_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.stallFetch = bus.fetchReq & ~bus.fetchAck;
    assign bus.stallData  = bus.dataReq & ~bus.dataAck;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed bench with a transaction-level arbiter model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int W      = 32;
    localparam int IW     = 16;
    localparam int L      = 2;
    localparam int STARVE = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.WIDTH(W), .INSTRUCTIONWIDTH(IW)) bus  ();
    mem_port_arbiter_if #(.WIDTH(W), .INSTRUCTIONWIDTH(IW)) bus1 ();

    mem_port_arbiter #(.WIDTH(W), .INSTRUCTIONWIDTH(IW), .LATENCY(L), .STARVELIMIT(STARVE)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    mem_port_arbiter #(.WIDTH(W), .INSTRUCTIONWIDTH(IW), .LATENCY(1), .STARVELIMIT(STARVE)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int wr_cnt  = 0;
    int ack_cnt = 0;
    int wr1_cnt = 0;
    byte ack_q[$];

    // Model: one access in flight, described by its grant cycle and latched request.
    bit          m_active = 1'b0;
    int          m_g      = 0;
    bit          m_own_fetch;
    logic [31:0] m_addr, m_wdata, m_rdata;
    bit          m_wr;
    int          m_streak = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        bit e_en, e_wr, e_fa, e_da, e_busy, own_fetch;
        if (!reset) begin
            m_active = 1'b0;
            m_streak = 0;
            chk("rst_busy",      bus.busy,      0);
            chk("rst_memEnable", bus.memEnable, 0);
            chk("rst_memWrite",  bus.memWrite,  0);
            chk("rst_fetchAck",  bus.fetchAck,  0);
            chk("rst_dataAck",   bus.dataAck,   0);
            chk("rst_memAddr",   bus.memAddr,   0);
            chk("rst_memWdata",  bus.memWdata,  0);
            chk("rst_fetchData", bus.fetchData, 0);
            chk("rst_dataRdata", bus.dataRdata, 0);
        end else begin
            if (m_active && cyc >= m_g + L + 2) m_active = 1'b0;
            e_en   = m_active && cyc > m_g && cyc <= m_g + L;
            e_wr   = e_en && cyc == m_g + L && m_wr;
            e_fa   = m_active && cyc == m_g + L + 1 && m_own_fetch;
            e_da   = m_active && cyc == m_g + L + 1 && !m_own_fetch;
            e_busy = m_active && cyc > m_g;
            chk("busy",       bus.busy,       e_busy);
            chk("memEnable",  bus.memEnable,  e_en);
            chk("memWrite",   bus.memWrite,   e_wr);
            chk("fetchAck",   bus.fetchAck,   e_fa);
            chk("dataAck",    bus.dataAck,    e_da);
            chk("stallFetch", bus.stallFetch, bus.fetchReq && !e_fa);
            chk("stallData",  bus.stallData,  bus.dataReq && !e_da);
            if (e_en) chk("memAddr",  bus.memAddr,  m_addr);
            if (e_wr) chk("memWdata", bus.memWdata, m_wdata);
            if (e_fa) chk("fetchData", bus.fetchData, m_rdata[IW-1:0]);
            if (e_da) chk("dataRdata", bus.dataRdata, m_rdata);
            if (m_active && cyc == m_g + L) m_rdata = bus.memRdata;
            if (!m_active && (bus.fetchReq || bus.dataReq)) begin
                own_fetch   = bus.fetchReq && (!bus.dataReq || m_streak == STARVE);
                m_active    = 1'b1;
                m_g         = cyc;
                m_own_fetch = own_fetch;
                if (own_fetch) begin
                    m_addr   = bus.fetchAddr;
                    m_wr     = 1'b0;
                    m_streak = 0;
                end else begin
                    m_addr   = bus.dataAddr;
                    m_wr     = bus.dataWrite;
                    m_wdata  = bus.dataWdata;
                    m_streak = bus.fetchReq ? ((m_streak < STARVE) ? m_streak + 1 : STARVE) : 0;
                end
            end
        end
        if (bus.memWrite === 1'b1) wr_cnt++;
        if (bus.fetchAck === 1'b1) begin ack_cnt++; ack_q.push_back("F"); end
        if (bus.dataAck === 1'b1)  begin ack_cnt++; ack_q.push_back("D"); end
        if (bus1.memWrite === 1'b1) wr1_cnt++;
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_order;
        int wr0, a0;
        bus.fetchReq = 0;  bus.fetchAddr = 0; bus.dataReq = 0; bus.dataWrite = 0;
        bus.dataAddr = 0;  bus.dataWdata = 0; bus.memRdata = 0;
        bus1.fetchReq = 0; bus1.fetchAddr = 0; bus1.dataReq = 0; bus1.dataWrite = 0;
        bus1.dataAddr = 0; bus1.dataWdata = 0; bus1.memRdata = 0;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        chk("reset_busy", bus.busy, 0);

        // Fetch only
        next(); bus.fetchReq = 1; bus.fetchAddr = 32'h10;
        next(); chk("f1_en", bus.memEnable, 1); chk("f1_addr", bus.memAddr, 32'h10);
                chk("f1_stall", bus.stallFetch, 1);
        next(); chk("f2_en", bus.memEnable, 1); bus.memRdata = 32'h0000ABCD;
        next(); chk("f3_ack", bus.fetchAck, 1); chk("f3_data", bus.fetchData, 16'hABCD);
                chk("f3_en", bus.memEnable, 0); chk("f3_stall", bus.stallFetch, 0);
                bus.fetchReq = 0;
        next(); chk("f4_busy", bus.busy, 0);

        // Simultaneous requests
        next(); bus.fetchReq = 1; bus.fetchAddr = 32'h20;
                bus.dataReq = 1; bus.dataWrite = 0; bus.dataAddr = 32'h80; bus.memRdata = 32'h11112222;
        next(); next();
        next(); chk("s3_dack", bus.dataAck, 1); chk("s3_fack", bus.fetchAck, 0);
                chk("s3_rdata", bus.dataRdata, 32'h11112222); bus.dataReq = 0;
        next(); chk("s4_busy", bus.busy, 0); chk("s4_stall", bus.stallFetch, 1);
        next(); chk("s5_en", bus.memEnable, 1); chk("s5_addr", bus.memAddr, 32'h20);
        next();
        next(); chk("s7_fack", bus.fetchAck, 1); chk("s7_data", bus.fetchData, 16'h2222);
                bus.fetchReq = 0;

        // Store, with address/data changed after the grant
        next(); bus.dataReq = 1; bus.dataWrite = 1; bus.dataAddr = 32'h40; bus.dataWdata = 32'hDEADBEEF;
        next(); chk("w1_wr", bus.memWrite, 0); chk("w1_en", bus.memEnable, 1);
                bus.dataAddr = 32'h44; bus.dataWdata = 32'h0;
        next(); chk("w2_wr", bus.memWrite, 1); chk("w2_addr", bus.memAddr, 32'h40);
                chk("w2_wdata", bus.memWdata, 32'hDEADBEEF);
        next(); chk("w3_ack", bus.dataAck, 1); chk("w3_wr", bus.memWrite, 0);
                bus.dataReq = 0; bus.dataWrite = 0;
        next();

        // Starvation: both requesters held high
        ack_q.delete();
        next(); bus.fetchReq = 1; bus.dataReq = 1; bus.fetchAddr = 32'h100; bus.dataAddr = 32'h200;
        for (int k = 0; k < 60; k++) begin
            next();
            if (ack_q.size() >= 8) break;
        end
        bus.fetchReq = 0; bus.dataReq = 0;
        exp_order = "DDDFDDDF";
        for (int i = 0; i < 8; i++) begin
            chk("starve_order", (i < ack_q.size()) ? ack_q[i] : 8'h0, exp_order[i]);
        end
        next(); next();

        // Reset in the first access cycle of a store
        next(); wr0 = wr_cnt; a0 = ack_cnt;
                bus.dataReq = 1; bus.dataWrite = 1; bus.dataAddr = 32'h50; bus.dataWdata = 32'h12345678;
        next();
        #2 reset = 1'b0;
        #1 chk("r_en", bus.memEnable, 0); chk("r_wr", bus.memWrite, 0); chk("r_busy", bus.busy, 0);
           chk("r_addr", bus.memAddr, 0); chk("r_wdata", bus.memWdata, 0);
           bus.dataReq = 0; bus.dataWrite = 0;
        next(); next(); reset = 1'b1;
        next(); chk("r_busy_after", bus.busy, 0);
        next(); chk("r_no_write", wr_cnt, wr0); chk("r_no_ack", ack_cnt, a0);
        next(); bus.fetchReq = 1; bus.fetchAddr = 32'h30;
        next(); next();
        next(); chk("r_fetch_ack", bus.fetchAck, 1); bus.fetchReq = 0;
        next(); chk("r_idle", bus.busy, 0);

        // LATENCY=1 instance: single load
        next(); bus1.dataReq = 1; bus1.dataWrite = 0; bus1.dataAddr = 32'h8; bus1.memRdata = 32'hCAFE55AA;
        next(); chk("l1_en", bus1.memEnable, 1); chk("l1_addr", bus1.memAddr, 32'h8);
                chk("l1_noack", bus1.dataAck, 0);
        next(); chk("l1_ack", bus1.dataAck, 1); chk("l1_rdata", bus1.dataRdata, 32'hCAFE55AA);
                bus1.dataReq = 0;
        next(); chk("l1_idle", bus1.busy, 0);
        chk("l1_never_wr", wr1_cnt, 0);
        next(); next();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the CPU's single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores). It serialises accesses, counts a fixed memory latency, returns read data with a one-cycle acknowledge, and drives per-stage stall lines that the pipeline ORs into its existing `stallF`/`stallD` hazard signals. It sits between the pipeline and `mem`, replacing the direct `PCF` and data-address connections.

## Interface
- `WIDTH`, 32: data and address width.
- `INSTRUCTIONWIDTH`, 16: instruction width returned to fetch.
- `LATENCY`, 2: cycles an access occupies the memory. Must be ≥1.
- `STARVELIMIT`, 3: maximum consecutive data grants while fetch is pending.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `fetchReq` in 1: fetch read request, held until `fetchAck`.
- `fetchAddr` in WIDTH: fetch address, stable while `fetchReq` is high.
- `fetchAck` out 1: one-cycle completion pulse.
- `fetchData` out INSTRUCTIONWIDTH: instruction, valid while `fetchAck` is high.
- `dataReq` in 1: data request, held until `dataAck`.
- `dataWrite` in 1: 1 = store, 0 = load.
- `dataAddr` in WIDTH; `dataWdata` in WIDTH: both stable while `dataReq` is high.
- `dataAck` out 1: one-cycle completion pulse.
- `dataRdata` out WIDTH: load data, valid while `dataAck` is high.
- `memEnable` out 1; `memWrite` out 1; `memAddr` out WIDTH; `memWdata` out WIDTH; `memRdata` in WIDTH: memory-side port.
- `stallFetch` out 1: `fetchReq & !fetchAck` (combinational).
- `stallData` out 1: `dataReq & !dataAck` (combinational).
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states and transitions:
  - IDLE: no grant. Leaves IDLE at the edge where any request is high. Owner, address, write flag and write data are latched at that edge.
  - ACCESS: lasts exactly LATENCY cycles, tracked by a down-counter loaded with LATENCY-1. Drives `memEnable`=1 and `memAddr`/`memWdata` from the latched registers.
  - RESP: lasts 1 cycle. Pulses the owner's ack and drives the response register. Always returns to IDLE.
- Store timing: `memWrite` is high only in the final ACCESS cycle (counter = 0), so each store commits exactly once.
- Load timing: `memRdata` is sampled at the edge ending the final ACCESS cycle into a response register. `dataRdata` carries the full register. `fetchData` carries bits [INSTRUCTIONWIDTH-1:0].
- Priority:
  - Data wins by default (it belongs to the older instruction).
  - If fetch is pending and the streak counter equals STARVELIMIT, fetch wins.
- Streak counter, width $clog2(STARVELIMIT+1):
  - Increments on a data grant while `fetchReq` is high.
  - Clears on any fetch grant, or on a data grant while fetch is idle.
  - Saturates at STARVELIMIT.
- Fetch accesses never write.
- Protocol violations:
  - A requester that drops its request before ack has still committed its access. The access completes and ack pulses anyway.
  - Address or data changes after the grant are ignored, because the values are latched.
- Reset (active-low, async) forces the following immediately, including mid-access:
  - FSM to IDLE, counters to 0.
  - `memEnable`, `memWrite`, `fetchAck`, `dataAck`, `busy` to 0.
  - `memAddr`, `memWdata`, `fetchData`, `dataRdata` to 0.
- An in-flight store aborted before its final ACCESS cycle is not written. No ack is issued for an aborted access.

## Timing
- Request high in IDLE cycle t: ACCESS occupies t+1..t+LATENCY, ack in t+LATENCY+1, IDLE at t+LATENCY+2.
- Request-to-ack latency: LATENCY+1 cycles. Throughput: one access per LATENCY+2 cycles.
- The requester may present a new request in the IDLE cycle after ack. The arbiter samples requests only in IDLE.
- Stall outputs are combinational from `*Req` and the registered ack. No other combinational input-to-output paths exist; memory-side outputs are registered.

## Structure
- Shared package `cpu_pkg` holds:
  - `arb_state_t` enum {IDLE, ACCESS, RESP}.
  - `arb_owner_t` enum {OWN_FETCH, OWN_DATA}.
- One combinational sub-module, `mem_arb_pick`. Inputs: `fetchReq`, `dataReq`, streak counter, STARVELIMIT. Output: granted owner. The FSM, counters and registers live in the top.

## Test plan
- Fetch only (LATENCY=2):
  - Stimulus: `fetchReq` in cycle 0, `fetchAddr`=0x10, `memRdata`=0x0000ABCD in cycle 2.
  - Required: `memEnable` in cycles 1–2 with `memAddr`=0x10; `fetchAck`=1 and `fetchData`=0xABCD in cycle 3; `stallFetch` high in cycles 0–2.
- Simultaneous requests:
  - Stimulus: both requests in cycle 0.
  - Required: `dataAck` in cycle 3; fetch granted from the cycle-4 IDLE; `fetchAck` in cycle 7; `stallFetch` high in cycles 0–6.
- Store:
  - Stimulus: `dataWrite`=1, `dataAddr`=0x40, `dataWdata`=0xDEADBEEF in cycle 0.
  - Required: `memWrite` high only in cycle 2 with `memAddr`=0x40 and `memWdata`=0xDEADBEEF; `dataAck` in cycle 3.
- Starvation (STARVELIMIT=3):
  - Stimulus: both requests held continuously, data re-requesting after every ack.
  - Required: grant order D,D,D,F,D,D,D,F.
- Reset mid-store:
  - Stimulus: reset low during cycle 1 of a store.
  - Required: `memEnable`/`memWrite` drop at once; no write and no ack occur; after release `busy`=0, and a fresh fetch completes normally with ack at t+3.
- LATENCY=1 build:
  - Stimulus: a single load.
  - Required: ack 2 cycles after the request; `memWrite` never asserted.
